// File: rtl/edl_button_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | edl_button_ctrl: Avalon-MM button block -- sync, debounce, edge capture,  |
// | irq. Debounce counters built only with EDL_BUTTON_DEBOUNCE_EN.   Rev 1.0  |
// +--------------------------------------------------------------------------+
module edl_button_ctrl #(
  parameter int WIDTH           = 2,
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [1:0]       address,
  input  logic             chipselect,
  input  logic             write_n,
  input  logic [31:0]      writedata,
  output logic [31:0]      readdata,
  input  logic [WIDTH-1:0] in_port,
  output logic             irq
);

  localparam logic [1:0] ADDR_DATA     = 2'd0;
  localparam logic [1:0] ADDR_IRQ_MASK = 2'd1;
  localparam logic [1:0] ADDR_EDGE_CAP = 2'd2;
  localparam logic [1:0] ADDR_EDGE_SEL = 2'd3;

  logic [WIDTH-1:0] sync_q;
  logic [WIDTH-1:0] s_q;
  logic [WIDTH-1:0] db_q,       db_d;
  logic [WIDTH-1:0] mask_q,     mask_d;
  logic [WIDTH-1:0] edge_cap_q, edge_cap_d;
  logic [WIDTH-1:0] edge_sel_q, edge_sel_d;
  logic [31:0]      readdata_q, readdata_d;
  logic             irq_q,      irq_d;

  logic             wr;
  logic [WIDTH-1:0] wdata;
  logic [WIDTH-1:0] rise, fall, cap_set, cap_clr;

  // Upper writedata bits are deliberately ignored.
  logic unused_ok;
  assign unused_ok = ^{writedata, (DEBOUNCE_CYCLES > 1)};

  assign wr    = chipselect & ~write_n;
  assign wdata = writedata[WIDTH-1:0];

`ifdef EDL_BUTTON_DEBOUNCE_EN
  localparam int               CNT_W   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [CNT_W-1:0] cnt_q [WIDTH];
  logic [CNT_W-1:0] cnt_d [WIDTH];

  // Accept s only after it has differed from db for DEBOUNCE_CYCLES cycles.
  always_comb begin
    for (int i = 0; i < WIDTH; i++) begin
      db_d[i]  = db_q[i];
      cnt_d[i] = '0;
      if (s_q[i] != db_q[i]) begin
        if (cnt_q[i] == CNT_MAX) begin
          db_d[i] = s_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= '0;
    end else begin
      for (int i = 0; i < WIDTH; i++) cnt_q[i] <= cnt_d[i];
    end
  end
`else
  always_comb begin
    db_d = s_q;
  end
`endif

  // A capture landing on the same edge as a write-1-clear takes priority.
  always_comb begin
    rise       = db_d & ~db_q;
    fall       = ~db_d & db_q;
    cap_set    = (rise & ~edge_sel_q) | (fall & edge_sel_q);
    cap_clr    = (wr && address == ADDR_EDGE_CAP) ? wdata : '0;
    edge_cap_d = (edge_cap_q & ~cap_clr) | cap_set;
    mask_d     = (wr && address == ADDR_IRQ_MASK) ? wdata : mask_q;
    edge_sel_d = (wr && address == ADDR_EDGE_SEL) ? wdata : edge_sel_q;
    irq_d      = |(edge_cap_q & mask_q);
  end

  always_comb begin
    readdata_d = '0;
    if (chipselect) begin
      case (address)
        ADDR_DATA:     readdata_d[WIDTH-1:0] = db_q;
        ADDR_IRQ_MASK: readdata_d[WIDTH-1:0] = mask_q;
        ADDR_EDGE_CAP: readdata_d[WIDTH-1:0] = edge_cap_q;
        ADDR_EDGE_SEL: readdata_d[WIDTH-1:0] = edge_sel_q;
        default:       readdata_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= '0;
      s_q        <= '0;
      db_q       <= '0;
      mask_q     <= '0;
      edge_cap_q <= '0;
      edge_sel_q <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      sync_q     <= in_port;
      s_q        <= sync_q;
      db_q       <= db_d;
      mask_q     <= mask_d;
      edge_cap_q <= edge_cap_d;
      edge_sel_q <= edge_sel_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata = readdata_q;
  assign irq      = irq_q;

endmodule
`default_nettype wire

// File: tb/tb_edl_button_ctrl.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_edl_button_ctrl: directed self-checking bench for edl_button_ctrl.     |
// | Rev 1.0                                                                   |
// +--------------------------------------------------------------------------+
module tb_edl_button_ctrl;

  localparam int WIDTH = 2;
  localparam int DC    = 4;
`ifdef EDL_BUTTON_DEBOUNCE_EN
  localparam int LAT = DC;
`else
  localparam int LAT = 1;
`endif

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic [1:0]       address = 2'd0;
  logic             chipselect = 1'b1;
  logic             write_n = 1'b1;
  logic [31:0]      writedata = '0;
  logic [31:0]      readdata;
  logic [WIDTH-1:0] in_port = '0;
  logic             irq;

  int n_checks = 0;
  int n_pass   = 0;

  edl_button_ctrl #(.WIDTH(WIDTH), .DEBOUNCE_CYCLES(DC)) u_dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .in_port    (in_port),
    .irq        (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance n rising edges, then settle 1 ns past the last one.
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic write_reg(input logic [1:0] a, input logic [31:0] d);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    step(1);
    write_n = 1'b1; address = 2'd0; writedata = '0;
  endtask

  task automatic read_reg(input logic [1:0] a, output logic [31:0] v);
    chipselect = 1'b1; address = a;
    step(1);
    v = readdata;
    address = 2'd0;
  endtask

  task automatic do_reset();
    reset_n = 1'b0; in_port = '0; chipselect = 1'b1; write_n = 1'b1; address = 2'd0;
    step(2);
    reset_n = 1'b1;
    step(3);
  endtask

  logic [31:0] v;

  initial begin
    // ---- asynchronous reset mid-count ----
    do_reset();
    write_reg(2'd1, 32'h3);
    write_reg(2'd3, 32'h2);
    address = 2'd1;
    in_port = 2'b01;
    step(3);
    check("pre_reset_mask", readdata, 32'h3);
    #3 reset_n = 1'b0;
    #1;
    check("reset_readdata", readdata, 32'h0);
    check("reset_irq", {31'b0, irq}, 32'h0);
    address = 2'd0;
    #1 reset_n = 1'b1;
    step(2 + LAT);
    check("reset_data_still0", readdata, 32'h0);
    step(1);
    check("reset_data_fresh", readdata, 32'h1);
    read_reg(2'd1, v); check("reset_mask0", v, 32'h0);
    read_reg(2'd3, v); check("reset_sel0", v, 32'h0);
    read_reg(2'd2, v); check("reset_cap_rise", v, 32'h1);

    // ---- clean press, irq, W1C clear ----
    do_reset();
    write_reg(2'd1, 32'h1);
    in_port = 2'b01;
    step(2 + LAT);
    check("press_data_lag", readdata, 32'h0);
    check("press_irq_lag", {31'b0, irq}, 32'h0);
    step(1);
    check("press_data", readdata, 32'h1);
    check("press_irq", {31'b0, irq}, 32'h1);
    read_reg(2'd2, v); check("press_cap", v, 32'h1);
    write_reg(2'd0, 32'h0);
    read_reg(2'd0, v); check("data_write_ignored", v, 32'h1);
    chipselect = 1'b0;
    step(1);
    check("no_cs_zero", readdata, 32'h0);
    chipselect = 1'b1;
    write_reg(2'd2, 32'h1);
    check("clr_irq_same_edge", {31'b0, irq}, 32'h1);
    step(1);
    check("clr_irq_fall", {31'b0, irq}, 32'h0);
    read_reg(2'd2, v); check("clr_cap", v, 32'h0);
    write_reg(2'd1, 32'hFFFF_FFFF);
    read_reg(2'd1, v); check("mask_upper_zero", v, 32'h3);

    // ---- bounce ----
    do_reset();
    for (int t = 0; t < 10; t++) begin
      in_port[0] = ~in_port[0];
      step(2);
`ifdef EDL_BUTTON_DEBOUNCE_EN
      check("bounce_data0", readdata, 32'h0);
`endif
    end
    in_port[0] = 1'b1;
    step(2 + LAT);
`ifdef EDL_BUTTON_DEBOUNCE_EN
    check("bounce_settle_lag", readdata, 32'h0);
`endif
    step(1);
    check("bounce_settle", readdata, 32'h1);
    read_reg(2'd2, v); check("bounce_cap", v, 32'h1);

    // ---- falling select on bit 1 ----
    do_reset();
    write_reg(2'd3, 32'h2);
    in_port = 2'b10;
    step(4 + LAT);
    read_reg(2'd0, v); check("fall_press_data", v, 32'h2);
    read_reg(2'd2, v); check("fall_press_nocap", v, 32'h0);
    in_port = 2'b00;
    step(4 + LAT);
    read_reg(2'd2, v); check("fall_release_cap", v, 32'h2);

    // ---- clear race ----
    do_reset();
    write_reg(2'd1, 32'h1);
    in_port = 2'b01;
    step(4 + LAT);
    in_port = 2'b00;
    step(4 + LAT);
    check("race_irq_pre", {31'b0, irq}, 32'h1);
    in_port = 2'b01;
    step(1 + LAT);
    write_reg(2'd2, 32'h1);
    check("race_irq_edge", {31'b0, irq}, 32'h1);
    step(1);
    check("race_irq_after", {31'b0, irq}, 32'h1);
    read_reg(2'd2, v); check("race_cap_kept", v, 32'h1);
    write_reg(2'd2, 32'h0);
    read_reg(2'd2, v); check("w0_no_change", v, 32'h1);
    write_reg(2'd1, 32'h0);
    check("mask_off_edge", {31'b0, irq}, 32'h1);
    step(1);
    check("mask_off_irq", {31'b0, irq}, 32'h0);
    read_reg(2'd2, v); check("mask_off_cap", v, 32'h1);
    write_reg(2'd1, 32'h1);
    check("unmask_edge", {31'b0, irq}, 32'h0);
    step(1);
    check("unmask_irq", {31'b0, irq}, 32'h1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/edl_button_ctrl.md
# edl_button_ctrl

Avalon-MM button controller that replaces the bare input PIO on the button pins with per-button synchronisation, debounce, edge capture and interrupt generation. It sits between the board push-buttons and the Nios II system interconnect. The CPU polls clean button state or takes an interrupt on a press or release instead of sampling raw bouncing inputs.

## Interface
- WIDTH, 2: number of buttons (1..32).
- DEBOUNCE_CYCLES, 50000: consecutive stable clk cycles required to accept a new level (1 ms at 50 MHz); minimum 2.
- clk  in  1  system clock.
- reset_n  in  1  reset; asynchronous, active-low.
- address  in  2  Avalon word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe; a write occurs when chipselect=1 and write_n=0.
- writedata  in  32  write data.
- readdata  out  32  registered read data.
- in_port  in  WIDTH  raw asynchronous button levels.
- irq  out  1  level interrupt to the CPU, active-high.

## Operation
- Register map:
  - 0 DATA: RO, debounced state db[WIDTH-1:0].
  - 1 IRQ_MASK: RW, per-bit interrupt enable.
  - 2 EDGE_CAP: RO status; writing 1 to a bit clears that bit; writing 0 leaves it unchanged.
  - 3 EDGE_SEL: RW, per bit; 0 captures rising transitions of db, 1 captures falling transitions.
- Unused upper readdata bits read 0. Writes to DATA are ignored. Only writedata[WIDTH-1:0] is used.
- Synchroniser: two flops per bit from in_port to s. Reset value 0.
- Debounce, per bit:
  - Counter cnt has width clog2(DEBOUNCE_CYCLES).
  - If s==db, cnt<=0.
  - Otherwise cnt increments. When cnt==DEBOUNCE_CYCLES-1 and s!=db, db<=s and cnt<=0.
  - Any cycle with s==db before that point restarts the count. No saturation or wrap is reachable.
- Edge capture: when db[i] updates, EDGE_CAP[i] is set if the direction matches EDGE_SEL[i].
  - If a set and a write-1-clear hit the same bit in the same cycle, the set wins.
  - A set on an already-set bit leaves the bit at 1. Captures are not counted.
- irq: registered, irq <= |(EDGE_CAP & IRQ_MASK), evaluated from the register values before the current edge.
- Changing IRQ_MASK or EDGE_SEL never alters EDGE_CAP. Unmasking an already-captured bit raises irq one cycle after the write.
- Reset values:
  - readdata=0, irq=0.
  - s, db, cnt = 0.
  - IRQ_MASK=0, EDGE_CAP=0, EDGE_SEL=0.
- Reset is asynchronous and may be asserted mid-debounce. All state returns to reset values immediately, and any in-flight transition is discarded.

## Timing
- Read: readdata is valid on the clock edge after chipselect with write_n=1. It is updated every cycle from address, with the mux output gated by chipselect (0 when not selected). Latency is 1, with no wait states.
- Write: takes effect on the same clock edge it is presented.
- in_port step at edge k: s changes at edge k+2. With debounce compiled in, db changes at edge k+2+DEBOUNCE_CYCLES.
- EDGE_CAP sets on the same edge db changes. irq rises on the following edge.
- EDGE_CAP clear at edge w: irq falls at edge w+1, provided no other masked bit remains set.

## Configuration
- EDL_BUTTON_DEBOUNCE_EN defined: debounce counters are built as described, and DEBOUNCE_CYCLES is honoured.
- EDL_BUTTON_DEBOUNCE_EN undefined:
  - No counters are built and DEBOUNCE_CYCLES is ignored.
  - db <= s every cycle, so db changes at edge k+3 after an in_port step at edge k.
  - Edge capture and irq behave identically on the undebounced db.

## Test plan
Tests use WIDTH=2 and DEBOUNCE_CYCLES=4 with the macro defined, unless stated otherwise.
- Reset: assert reset_n=0 mid-count with s[0]!=db[0] -> all registers, readdata and irq read 0 immediately; after release, DATA reads 0 until a fresh 4-cycle stable run completes.
- Clean press: in_port 00->01 at edge 0 -> DATA=1 at edge 6, EDGE_CAP=01 at edge 6; with IRQ_MASK=01, irq=1 at edge 7.
- Bounce: toggle in_port[0] every 2 cycles for 20 cycles, then hold at 1 -> DATA stays 0 throughout toggling, then becomes 1 exactly 4 cycles after s settles; EDGE_CAP[0] sets once.
- Falling select: EDGE_SEL=10, press then release button 1 -> EDGE_CAP[1] is set only on release; the press leaves it 0.
- Clear race: write EDGE_CAP=01 on the same edge a new rising capture on bit 0 occurs -> bit 0 remains 1 and irq stays 1; write 00 -> no change; mask 00 -> irq=0 next cycle with EDGE_CAP unchanged.
- Macro undefined: step in_port[1] at edge 0 -> DATA[1]=1 at edge 3, irq=1 at edge 4 with IRQ_MASK=10.
